// File: rtl/eager_fork_register_block.sv
// Per-output state of the eager fork: remembers whether this output already took the current token.
// Latency 0: outs_valid and the ready term are combinational from the flag and the inputs.
// Backpressure: a stalled consumer keeps its flag clear, and its ready term holds the shared ins_ready low.
//
// Ports:
//   clk, rst    : clock and synchronous active-high reset (clears the sent flag)
//   ins_valid   : upstream token valid, shared by every output
//   outs_ready  : this output's consumer ready
//   consume     : the upstream token is consumed this cycle; clear the flag for the next token
//   outs_valid  : this output's valid (token present and not yet delivered here)
//   ready_term  : sent | outs_ready, which the top level ANDs into ins_ready
module eager_fork_register_block (
    input  logic clk,
    input  logic rst,
    input  logic ins_valid,
    input  logic outs_ready,
    input  logic consume,
    output logic outs_valid,
    output logic ready_term
);

    logic sent_q;
    logic sent_d;
    logic xfer;

    always_comb begin
        outs_valid = ins_valid & ~sent_q;
        xfer       = outs_valid & outs_ready;
        ready_term = sent_q | outs_ready;
        // Consumption wins over a same-cycle transfer: the flag must start clear for the next token.
        if (consume) begin
            sent_d = 1'b0;
        end else begin
            sent_d = sent_q | xfer;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sent_q <= 1'b0;
        end else begin
            sent_q <= sent_d;
        end
    end

endmodule

// File: rtl/eager_fork.sv
// Eager elastic fork: copies one input token to SIZE outputs. Each output takes its copy independently.
// Latency 0: data, valids and ins_ready are all combinational. The only state is one sent flag per output.
// Backpressure: ins_ready rises only when every output has either already taken the token or is taking it now.
//
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   ins         : input token data, DATA_TYPE bits
//   ins_valid   : input token valid
//   ins_ready   : the fork accepts the input token this cycle
//   outs        : SIZE copies of ins; channel i is outs[i*DATA_TYPE +: DATA_TYPE]
//   outs_valid  : per-output valid
//   outs_ready  : per-output ready
module eager_fork #(
    parameter int SIZE      = 2,
    parameter int DATA_TYPE = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_TYPE-1:0]      ins,
    input  logic                      ins_valid,
    output logic                      ins_ready,
    output logic [SIZE*DATA_TYPE-1:0] outs,
    output logic [SIZE-1:0]           outs_valid,
    input  logic [SIZE-1:0]           outs_ready
);

    logic [SIZE-1:0] ready_terms;
    logic            consume;

    // ins_ready does not look at ins_valid. That keeps the upstream merge free of a valid->ready loop.
    assign ins_ready = &ready_terms;
    assign consume   = ins_valid & ins_ready;
    assign outs      = {SIZE{ins}};

    for (genvar i = 0; i < SIZE; i++) begin : g_out
        eager_fork_register_block u_reg (
            .clk        (clk),
            .rst        (rst),
            .ins_valid  (ins_valid),
            .outs_ready (outs_ready[i]),
            .consume    (consume),
            .outs_valid (outs_valid[i]),
            .ready_term (ready_terms[i])
        );
    end

endmodule

// File: tb/tb_eager_fork.sv
module tb_eager_fork;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Two-output fork, 8-bit data
    logic [7:0]  ins2;
    logic        v2;
    logic        ir2;
    logic [15:0] outs2;
    logic [1:0]  ov2;
    logic [1:0]  rdy2;

    // Three-output fork
    logic [7:0]  ins3;
    logic        v3;
    logic        ir3;
    logic [23:0] outs3;
    logic [2:0]  ov3;
    logic [2:0]  rdy3;

    // Single-output fork
    logic [7:0]  ins1;
    logic        v1;
    logic        ir1;
    logic [7:0]  outs1;
    logic [0:0]  ov1;
    logic [0:0]  rdy1;

    eager_fork #(.SIZE(2), .DATA_TYPE(8)) dut2 (
        .clk(clk), .rst(rst), .ins(ins2), .ins_valid(v2), .ins_ready(ir2),
        .outs(outs2), .outs_valid(ov2), .outs_ready(rdy2));

    eager_fork #(.SIZE(3), .DATA_TYPE(8)) dut3 (
        .clk(clk), .rst(rst), .ins(ins3), .ins_valid(v3), .ins_ready(ir3),
        .outs(outs3), .outs_valid(ov3), .outs_ready(rdy3));

    eager_fork #(.SIZE(1), .DATA_TYPE(8)) dut1 (
        .clk(clk), .rst(rst), .ins(ins1), .ins_valid(v1), .ins_ready(ir1),
        .outs(outs1), .outs_valid(ov1), .outs_ready(rdy1));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] ins;
        logic       v;
        logic [1:0] rdy;
        logic [1:0] exp_ov;
        logic       exp_ir;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    // Model state for the randomized-ready scoreboard run
    logic [1:0] sent_m;
    logic [7:0] lfsr;
    logic [7:0] toks[3];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [1:0] e_ov;
    logic       e_ir;
    int         idx;
    int         cyc;

    initial begin
        //            rst   ins    v     rdy    ov     ir
        vecs[0]  = '{1'b0, 8'hA5, 1'b1, 2'b11, 2'b11, 1'b1}; // all ready: one-cycle broadcast
        vecs[1]  = '{1'b0, 8'hA5, 1'b0, 2'b00, 2'b00, 1'b0}; // flags stayed clear
        vecs[2]  = '{1'b0, 8'h11, 1'b1, 2'b01, 2'b11, 1'b0}; // out0 takes 0x11
        vecs[3]  = '{1'b0, 8'h11, 1'b1, 2'b10, 2'b10, 1'b1}; // out1 last: release
        vecs[4]  = '{1'b0, 8'h33, 1'b1, 2'b01, 2'b11, 1'b0}; // fresh token, out0 takes
        vecs[5]  = '{1'b0, 8'h33, 1'b1, 2'b00, 2'b10, 1'b0}; // out1 stalls x5
        vecs[6]  = '{1'b0, 8'h33, 1'b1, 2'b00, 2'b10, 1'b0};
        vecs[7]  = '{1'b0, 8'h33, 1'b1, 2'b00, 2'b10, 1'b0};
        vecs[8]  = '{1'b0, 8'h33, 1'b1, 2'b00, 2'b10, 1'b0};
        vecs[9]  = '{1'b0, 8'h33, 1'b1, 2'b01, 2'b10, 1'b0}; // out0 ready ignored while done
        vecs[10] = '{1'b0, 8'h33, 1'b1, 2'b10, 2'b10, 1'b1};
        vecs[11] = '{1'b0, 8'h22, 1'b1, 2'b01, 2'b11, 1'b0}; // out0 takes 0x22
        vecs[12] = '{1'b1, 8'h22, 1'b1, 2'b00, 2'b10, 1'b0}; // reset mid-token
        vecs[13] = '{1'b0, 8'h22, 1'b1, 2'b00, 2'b11, 1'b0}; // 0x22 re-offered on out0
        vecs[14] = '{1'b0, 8'h22, 1'b1, 2'b11, 2'b11, 1'b1};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 2'b11, 2'b00, 1'b1}; // ins_ready independent of valid
        vecs[16] = '{1'b0, 8'h44, 1'b1, 2'b01, 2'b11, 1'b0}; // out0 takes 0x44
        vecs[17] = '{1'b0, 8'h44, 1'b0, 2'b10, 2'b00, 1'b1}; // valid low: flag held
        vecs[18] = '{1'b0, 8'h44, 1'b1, 2'b00, 2'b10, 1'b0};
        vecs[19] = '{1'b0, 8'h44, 1'b1, 2'b10, 2'b10, 1'b1};

        // Reset
        rst = 1'b1;
        ins2 = 8'h0; v2 = 1'b0; rdy2 = 2'b00;
        ins3 = 8'h0; v3 = 1'b0; rdy3 = 3'b000;
        ins1 = 8'h0; v1 = 1'b0; rdy1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ov2", {30'd0, ov2}, 32'd0);
        chk("reset_ir2", {31'd0, ir2}, 32'd0);
        chk("reset_ov3", {29'd0, ov3}, 32'd0);
        rdy2 = 2'b11;
        #1;
        chk("reset_ir2_allrdy", {31'd0, ir2}, 32'd1);

        // Directed vector table on the two-output fork
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            rst  = vecs[k].rst;
            ins2 = vecs[k].ins;
            v2   = vecs[k].v;
            rdy2 = vecs[k].rdy;
            #1;
            chk($sformatf("vec%0d_ov", k), {30'd0, ov2}, {30'd0, vecs[k].exp_ov});
            chk($sformatf("vec%0d_ir", k), {31'd0, ir2}, {31'd0, vecs[k].exp_ir});
            chk($sformatf("vec%0d_dat", k), {16'd0, outs2}, {16'd0, vecs[k].ins, vecs[k].ins});
        end
        @(negedge clk);
        rst = 1'b0; v2 = 1'b0; rdy2 = 2'b00;

        // Back-to-back tokens 1,2,3 with pseudo-random ready
        toks[0] = 8'd1; toks[1] = 8'd2; toks[2] = 8'd3;
        sent_m = 2'b00; lfsr = 8'hB7; idx = 0; cyc = 0;
        while (idx < 3 && cyc < 200) begin
            @(negedge clk);
            rdy2 = lfsr[1:0];
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            ins2 = toks[idx];
            v2   = 1'b1;
            #1;
            e_ov = ~sent_m;
            e_ir = &(sent_m | rdy2);
            chk($sformatf("lfsr%0d_ov", cyc), {30'd0, ov2}, {30'd0, e_ov});
            chk($sformatf("lfsr%0d_ir", cyc), {31'd0, ir2}, {31'd0, e_ir});
            if (ov2[0] && rdy2[0]) q0.push_back(outs2[7:0]);
            if (ov2[1] && rdy2[1]) q1.push_back(outs2[15:8]);
            if (e_ir) begin
                sent_m = 2'b00;
                idx++;
            end else begin
                sent_m = sent_m | (e_ov & rdy2);
            end
            cyc++;
        end
        chk("lfsr_done_in_budget", {31'd0, (idx == 3)}, 32'd1);
        @(negedge clk);
        v2 = 1'b0; rdy2 = 2'b00;
        chk("sb_out0_count", q0.size(), 32'd3);
        chk("sb_out1_count", q1.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sb_out0_tok%0d", k), (k < q0.size()) ? {24'd0, q0[k]} : 32'hFFFF, {24'd0, toks[k]});
            chk($sformatf("sb_out1_tok%0d", k), (k < q1.size()) ? {24'd0, q1[k]} : 32'hFFFF, {24'd0, toks[k]});
        end

        // Three-output fork: ready arrives one output per cycle
        @(negedge clk);
        ins3 = 8'h55; v3 = 1'b1; rdy3 = 3'b100;
        #1;
        chk("s3_c0_ov", {29'd0, ov3}, 32'h7);
        chk("s3_c0_ir", {31'd0, ir3}, 32'd0);
        @(negedge clk);
        rdy3 = 3'b001;
        #1;
        chk("s3_c1_ov", {29'd0, ov3}, 32'h3);
        chk("s3_c1_ir", {31'd0, ir3}, 32'd0);
        @(negedge clk);
        rdy3 = 3'b010;
        #1;
        chk("s3_c2_ov", {29'd0, ov3}, 32'h2);
        chk("s3_c2_ir", {31'd0, ir3}, 32'd1);
        chk("s3_c2_dat", {8'd0, outs3}, 32'h555555);
        @(negedge clk);
        ins3 = 8'h66; rdy3 = 3'b000;
        #1;
        chk("s3_c3_ov", {29'd0, ov3}, 32'h7);
        chk("s3_c3_ir", {31'd0, ir3}, 32'd0);
        @(negedge clk);
        v3 = 1'b0;

        // Single-output fork behaves as a wire
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ins1 = 8'h70 + 8'(k);
            v1   = 1'b1;
            rdy1 = 1'(k & 1);
            #1;
            chk($sformatf("s1_%0d_ov", k), {31'd0, ov1}, 32'd1);
            chk($sformatf("s1_%0d_ir", k), {31'd0, ir1}, k & 1);
            chk($sformatf("s1_%0d_dat", k), {24'd0, outs1}, 32'h70 + k);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
